keypad_time_loader: RTL and testbench

- Sequences keypad entry for the oven's cook-time input path.
- Samples the 10-key one-hot keypad, debounces each press, and accepts one digit per press.
- Shifts accepted digits into a 3-digit M:SS entry register and issues a one-cycle load pulse to the countdown timer on start.
- Sits between the raw keypad lines and the timer; ignores all entry while the magnetron is on (enablen high).

---
 rtl/keypad_time_loader_if.sv | 26 ++
 rtl/keypad_time_loader.sv | 137 +++++++++++++
 tb/tb_keypad_time_loader.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/keypad_time_loader_if.sv
// Keypad entry bundle: raw keypad/control inputs toward the loader, BCD digits and pulses back.
// master drives the keypad and control lines (keypad front end / test harness).
// slave is the loader itself.
interface keypad_time_loader_if;
  logic [9:0] keypad;
  logic       enablen;
  logic       clear_entry;
  logic       start_req;
  logic [3:0] sec_ones;
  logic [3:0] sec_tens;
  logic [3:0] min_ones;
  logic [1:0] digit_count;
  logic       key_strobe;
  logic       time_valid;
  logic       load;

  modport master (
    output keypad, enablen, clear_entry, start_req,
    input  sec_ones, sec_tens, min_ones, digit_count, key_strobe, time_valid, load
  );

  modport slave (
    input  keypad, enablen, clear_entry, start_req,
    output sec_ones, sec_tens, min_ones, digit_count, key_strobe, time_valid, load
  );
endinterface

// File: rtl/keypad_time_loader.sv
// Oven cook-time entry: debounces one-hot keypad presses and shifts digits into an M:SS register.
// Latency: key_strobe in the (DEBOUNCE_CYCLES+2)th cycle after the key is first sampled; load one cycle after start_req rises.
// No backpressure: presses while the magnetron runs, or starts that cannot be honoured, are dropped.
module keypad_time_loader #(
  parameter int unsigned DEBOUNCE_CYCLES = 20
) (
  input logic            clk,
  input logic            reset,
  keypad_time_loader_if.slave bus
);

  typedef enum logic [1:0] {IDLE, DEBOUNCE, ACCEPT, RELEASE} state_t;

  // Counter value at which the next stable sample completes the debounce window.
  localparam logic [7:0] DB_LAST = 8'(DEBOUNCE_CYCLES - 1);

  state_t     state;
  logic [9:0] key_q;
  logic [7:0] cnt;
  logic [3:0] cand;
  logic       start_q;
  logic [3:0] so;
  logic [3:0] st;
  logic [3:0] mo;
  logic [1:0] count;
  logic       strobe;
  logic       load_r;

  logic       onehot;
  logic [3:0] code;
  logic       valid;
  logic       start_rise;

  // Decode the synchronised keys: a single pressed key yields its digit, anything else is "no key".
  always_comb begin
    onehot = 1'b0;
    code   = 4'd0;
    for (int k = 0; k < 10; k++) begin
      if (key_q == (10'd1 << k)) begin
        onehot = 1'b1;
        code   = 4'(k);
      end
    end
  end

  // A time is loadable once something was entered, the seconds tens digit is sane and it is not 0:00.
  assign valid      = (count != 2'd0) && (st <= 4'd5) && ({mo, st, so} != 12'd0);
  assign start_rise = bus.start_req && !start_q;

  // Input sync, debounce FSM, digit shift register and the registered strobe/load pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      key_q   <= 10'd0;
      cnt     <= 8'd0;
      cand    <= 4'd0;
      start_q <= 1'b0;
      so      <= 4'd0;
      st      <= 4'd0;
      mo      <= 4'd0;
      count   <= 2'd0;
      strobe  <= 1'b0;
      load_r  <= 1'b0;
    end else begin
      key_q   <= bus.keypad;
      start_q <= bus.start_req;
      strobe  <= 1'b0;
      load_r  <= 1'b0;
      if (bus.clear_entry) begin
        // Clear beats a pending accept and any start; a still-held key must be released first.
        so    <= 4'd0;
        st    <= 4'd0;
        mo    <= 4'd0;
        count <= 2'd0;
        cnt   <= 8'd0;
        if (!bus.enablen && (key_q != 10'd0)) begin
          state <= RELEASE;
        end else begin
          state <= IDLE;
        end
      end else if (bus.enablen) begin
        // Magnetron on: abandon any press in progress, keep the digits.
        state <= IDLE;
        cnt   <= 8'd0;
      end else begin
        if ((state == IDLE) && valid && start_rise) begin
          load_r <= 1'b1;
        end
        case (state)
          IDLE: begin
            if (onehot) begin
              state <= DEBOUNCE;
              cand  <= code;
              cnt   <= 8'd1;
            end
          end
          DEBOUNCE: begin
            if (onehot && (code == cand)) begin
              cnt <= cnt + 8'd1;
              if (cnt == DB_LAST) begin
                state <= ACCEPT;
              end
            end else begin
              state <= IDLE;
              cnt   <= 8'd0;
            end
          end
          ACCEPT: begin
            strobe <= 1'b1;
            mo     <= st;
            st     <= so;
            so     <= cand;
            count  <= (count == 2'd3) ? 2'd3 : count + 2'd1;
            cnt    <= 8'd0;
            state  <= RELEASE;
          end
          RELEASE: begin
            // No auto-repeat: the key must go fully up before another press is considered.
            if (key_q == 10'd0) begin
              state <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.sec_ones    = so;
  assign bus.sec_tens    = st;
  assign bus.min_ones    = mo;
  assign bus.digit_count = count;
  assign bus.key_strobe  = strobe;
  assign bus.time_valid  = valid;
  assign bus.load        = load_r;

endmodule

// File: tb/tb_keypad_time_loader.sv
// Bench for keypad_time_loader with DEBOUNCE_CYCLES=4: a table of held-input segments with
// expected digits/count/pulse totals, followed by hand-written timing and corner-case sequences.
module tb_keypad_time_loader;

  logic clk = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;
  int   strobe_seen;
  int   load_seen;

  keypad_time_loader_if bus ();

  keypad_time_loader #(.DEBOUNCE_CYCLES(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [9:0]  keypad;
    logic        enablen;
    logic        clear;
    logic        start;
    int          cycles;
    logic [11:0] exp_time;
    int          exp_cnt;
    int          exp_strobes;
    int          exp_loads;
    logic        exp_valid;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic [9:0] kp, input logic en, input logic cl, input logic st,
                     input int cyc, input logic [11:0] t, input int c, input int s,
                     input int l, input logic v);
    vec_t x;
    x.keypad = kp; x.enablen = en; x.clear = cl; x.start = st; x.cycles = cyc;
    x.exp_time = t; x.exp_cnt = c; x.exp_strobes = s; x.exp_loads = l; x.exp_valid = v;
    vq.push_back(x);
  endtask

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (bus.key_strobe) strobe_seen++;
    if (bus.load) load_seen++;
  endtask

  function automatic int cur_time();
    return int'({bus.min_ones, bus.sec_tens, bus.sec_ones});
  endfunction

  task automatic press(input int k);
    bus.keypad = 10'd1 << k;
    repeat (10) step();
    bus.keypad = 10'd0;
    repeat (3) step();
  endtask

  task automatic do_clear();
    bus.clear_entry = 1'b1;
    step();
    bus.clear_entry = 1'b0;
    step();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.keypad = 10'd0; bus.enablen = 1'b0; bus.clear_entry = 1'b0; bus.start_req = 1'b0;
    strobe_seen = 0; load_seen = 0;
    reset = 1'b1;
    step(); step();
    check("reset time", cur_time(), 0);
    check("reset count", int'(bus.digit_count), 0);
    check("reset strobe", int'(bus.key_strobe), 0);
    check("reset load", int'(bus.load), 0);
    check("reset valid", int'(bus.time_valid), 0);
    reset = 1'b0;

    //  keypad    en    clr   start cyc  M:SS    cnt str ld valid
    add(10'h000, 1'b0, 1'b0, 1'b0, 3,  12'h000, 0, 0, 0, 1'b0);
    add(10'h008, 1'b0, 1'b0, 1'b0, 10, 12'h003, 1, 1, 0, 1'b1);
    add(10'h000, 1'b0, 1'b0, 1'b0, 3,  12'h003, 1, 0, 0, 1'b1);
    add(10'h000, 1'b0, 1'b1, 1'b0, 2,  12'h000, 0, 0, 0, 1'b0);
    add(10'h002, 1'b0, 1'b0, 1'b0, 10, 12'h001, 1, 1, 0, 1'b1);
    add(10'h000, 1'b0, 1'b0, 1'b0, 3,  12'h001, 1, 0, 0, 1'b1);
    add(10'h008, 1'b0, 1'b0, 1'b0, 10, 12'h013, 2, 1, 0, 1'b1);
    add(10'h000, 1'b0, 1'b0, 1'b0, 3,  12'h013, 2, 0, 0, 1'b1);
    add(10'h001, 1'b0, 1'b0, 1'b0, 10, 12'h130, 3, 1, 0, 1'b1);
    add(10'h000, 1'b0, 1'b0, 1'b0, 3,  12'h130, 3, 0, 0, 1'b1);
    add(10'h020, 1'b0, 1'b0, 1'b0, 10, 12'h305, 3, 1, 0, 1'b1);
    add(10'h000, 1'b0, 1'b0, 1'b0, 3,  12'h305, 3, 0, 0, 1'b1);
    // bounce on key 7: 2 high, 1 low, 2 high
    add(10'h080, 1'b0, 1'b0, 1'b0, 2,  12'h305, 3, 0, 0, 1'b1);
    add(10'h000, 1'b0, 1'b0, 1'b0, 1,  12'h305, 3, 0, 0, 1'b1);
    add(10'h080, 1'b0, 1'b0, 1'b0, 2,  12'h305, 3, 0, 0, 1'b1);
    add(10'h000, 1'b0, 1'b0, 1'b0, 3,  12'h305, 3, 0, 0, 1'b1);
    // multi-key pattern held
    add(10'h00B, 1'b0, 1'b0, 1'b0, 10, 12'h305, 3, 0, 0, 1'b1);
    add(10'h000, 1'b0, 1'b0, 1'b0, 3,  12'h305, 3, 0, 0, 1'b1);
    // key 2 held with magnetron on, then enablen drops with key still down
    add(10'h004, 1'b1, 1'b0, 1'b0, 10, 12'h305, 3, 0, 0, 1'b1);
    add(10'h004, 1'b0, 1'b0, 1'b0, 10, 12'h052, 3, 1, 0, 1'b1);
    add(10'h000, 1'b0, 1'b0, 1'b0, 3,  12'h052, 3, 0, 0, 1'b1);
    // held start gives a single load
    add(10'h000, 1'b0, 1'b0, 1'b1, 3,  12'h052, 3, 0, 1, 1'b1);
    add(10'h000, 1'b0, 1'b0, 1'b0, 2,  12'h052, 3, 0, 0, 1'b1);
    // 0:70 is not loadable
    add(10'h000, 1'b0, 1'b1, 1'b0, 2,  12'h000, 0, 0, 0, 1'b0);
    add(10'h080, 1'b0, 1'b0, 1'b0, 10, 12'h007, 1, 1, 0, 1'b1);
    add(10'h000, 1'b0, 1'b0, 1'b0, 3,  12'h007, 1, 0, 0, 1'b1);
    add(10'h001, 1'b0, 1'b0, 1'b0, 10, 12'h070, 2, 1, 0, 1'b0);
    add(10'h000, 1'b0, 1'b0, 1'b0, 3,  12'h070, 2, 0, 0, 1'b0);
    add(10'h000, 1'b0, 1'b0, 1'b1, 3,  12'h070, 2, 0, 0, 1'b0);
    add(10'h000, 1'b0, 1'b0, 1'b0, 2,  12'h070, 2, 0, 0, 1'b0);

    for (int i = 0; i < vq.size(); i++) begin
      strobe_seen = 0;
      load_seen   = 0;
      bus.keypad      = vq[i].keypad;
      bus.enablen     = vq[i].enablen;
      bus.clear_entry = vq[i].clear;
      bus.start_req   = vq[i].start;
      repeat (vq[i].cycles) step();
      check($sformatf("row%0d time", i), cur_time(), int'(vq[i].exp_time));
      check($sformatf("row%0d count", i), int'(bus.digit_count), vq[i].exp_cnt);
      check($sformatf("row%0d strobes", i), strobe_seen, vq[i].exp_strobes);
      check($sformatf("row%0d loads", i), load_seen, vq[i].exp_loads);
      check($sformatf("row%0d valid", i), int'(bus.time_valid), int'(vq[i].exp_valid));
    end
    bus.keypad = 10'd0; bus.enablen = 1'b0; bus.clear_entry = 1'b0; bus.start_req = 1'b0;

    // Exact strobe timing: DEBOUNCE_CYCLES+2 = 6th cycle after the first sampling edge.
    do_clear();
    bus.keypad = 10'h200;
    for (int s = 1; s <= 8; s++) begin
      step();
      check($sformatf("timing strobe c%0d", s), int'(bus.key_strobe), (s == 6) ? 1 : 0);
      if (s == 5) check("timing digit before", int'(bus.sec_ones), 0);
      if (s == 6) check("timing digit at strobe", int'(bus.sec_ones), 9);
    end
    bus.keypad = 10'd0;
    repeat (3) step();

    // Load exactly one cycle after the start_req rising edge, once.
    do_clear();
    press(1); press(3); press(0);
    check("load entry 1:30", cur_time(), 12'h130);
    bus.start_req = 1'b1;
    step();
    check("load c1", int'(bus.load), 1);
    step();
    check("load c2", int'(bus.load), 0);
    step();
    check("load c3", int'(bus.load), 0);
    bus.start_req = 1'b0;
    step();
    check("load keeps digits", cur_time(), 12'h130);

    // clear_entry in the ACCEPT cycle wins: no shift, no strobe, held key needs release.
    strobe_seen = 0;
    bus.keypad = 10'h010;
    repeat (5) step();
    bus.clear_entry = 1'b1;
    step();
    check("clr-accept strobe", int'(bus.key_strobe), 0);
    check("clr-accept time", cur_time(), 0);
    check("clr-accept count", int'(bus.digit_count), 0);
    bus.clear_entry = 1'b0;
    repeat (8) step();
    check("clr-accept no repeat", strobe_seen, 0);
    bus.keypad = 10'd0;
    repeat (3) step();

    // Asynchronous reset in the middle of a debounce.
    press(1);
    check("pre-reset digit", int'(bus.sec_ones), 1);
    strobe_seen = 0;
    bus.keypad = 10'h040;
    repeat (3) step();
    reset = 1'b1;
    #1;
    check("midreset time", cur_time(), 0);
    check("midreset count", int'(bus.digit_count), 0);
    check("midreset strobe", int'(bus.key_strobe), 0);
    check("midreset valid", int'(bus.time_valid), 0);
    bus.keypad = 10'd0;
    step(); step();
    reset = 1'b0;
    repeat (8) step();
    check("post-reset strobes", strobe_seen, 0);
    check("post-reset time", cur_time(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
